// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit and its HI/LO registers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_t;

  localparam logic [31:0] DBZ_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_hilo_if.sv
// Issue/result bundle between the control unit and the mul/div unit.
interface muldiv_hilo_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, x, y, hi_we, lo_we, wdata,
                  input  busy, done, dbz, hi, lo);
  modport slave  (input  start, op, x, y, hi_we, lo_we, wdata,
                  output busy, done, dbz, hi, lo);
endinterface

// File: rtl/muldiv_core.sv
// Shift-add multiply / restoring divide datapath over a 2*WIDTH accumulator,
// with magnitude operands latched on load and sign fix-up applied combinationally.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  op_t              op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             dbz
);

  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [WIDTH-1:0]   m;
  logic               is_div, neg_q, neg_r;
  logic               sgn;
  logic [WIDTH-1:0]   ax, ay, q, r;
  logic [WIDTH:0]     mul_sum, trial;

  always_comb begin
    sgn = (op == OP_MULT) || (op == OP_DIV);
    ax  = (sgn && x[WIDTH-1]) ? -x : x;
    ay  = (sgn && y[WIDTH-1]) ? -y : y;
  end

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, m};
    acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      // Borrow means the shifted remainder is below the divisor, so it fits WIDTH bits.
      if (!trial[WIDTH]) acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else               acc_nxt = {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      m      <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
    end else if (load) begin
      is_div <= op[1];
      dbz    <= op[1] && (y == '0);
      neg_q  <= sgn && (x[WIDTH-1] ^ y[WIDTH-1]);
      neg_r  <= sgn && x[WIDTH-1];
      if (op[1]) begin
        acc <= {{WIDTH{1'b0}}, ax};
        // A zero divisor is never used, so m carries the raw dividend for HI instead.
        m   <= (y == '0) ? x : ay;
      end else begin
        acc <= {{WIDTH{1'b0}}, ay};
        m   <= ax;
      end
    end else if (step) begin
      acc <= acc_nxt;
    end
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    q    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (dbz) begin
      res_hi = m;
      res_lo = WIDTH'($signed(DBZ_LO));
    end else begin
      res_hi = r;
      res_lo = q;
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Mul/div sequencer: IDLE -> CALC (WIDTH iterations) -> FIX, plus the
// architectural HI/LO registers with MTHI/MTLO writes accepted only when idle.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_hilo_if.slave  bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, res_hi, res_lo;
  logic             done_q, dbz_q, core_dbz;
  logic             load, step;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .op     (op_t'(bus.op)),
    .x      (bus.x),
    .y      (bus.y),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .dbz    (core_dbz)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        load    = 1'b1;
        state_d = S_CALC;
      end
      S_CALC: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_FIX);
      if (load)      cnt_q <= CNT_W'(WIDTH);
      else if (step) cnt_q <= cnt_q - CNT_W'(1);
      if (load) dbz_q <= 1'b0;
      if (state_q == S_FIX) begin
        hi_q  <= res_hi;
        lo_q  <= res_lo;
        dbz_q <= core_dbz;
      end else if (state_q == S_IDLE && !bus.start) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed checks of muldiv_hilo: latency, products, quotients, divide-by-zero,
// MTHI/MTLO priority and mid-operation reset abort.
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  muldiv_hilo_if #(.WIDTH(32)) bus ();

  muldiv_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op at a negedge, scramble inputs afterwards, then track busy/done.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic hw, input logic [31:0] eh,
                        input logic [31:0] el, input logic ed);
    logic [31:0] hb;
    int n;
    @(negedge clk);
    hb         = bus.hi;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.x      = x;
    bus.y      = y;
    bus.hi_we  = hw;
    bus.wdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.hi_we  = 1'b0;
    bus.op     = ~op;
    bus.x      = 32'hA5A5_A5A5;
    bus.y      = 32'h0000_0000;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      if (n == 5) begin
        bus.hi_we = 1'b1;
        bus.wdata = 32'hCAFE_F00D;
      end else begin
        bus.hi_we = 1'b0;
      end
      if (n == 10) chk({tag, " hi_hold"}, 64'(bus.hi), 64'(hb));
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, 64'(n), 64'd33);
    chk({tag, " done"}, 64'(bus.done), 64'd1);
    chk({tag, " hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, " lo"}, 64'(bus.lo), 64'(el));
    chk({tag, " dbz"}, 64'(bus.dbz), 64'(ed));
    @(negedge clk);
    chk({tag, " done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic saw_done;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.x     = '0;
    bus.y     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst dbz",  64'(bus.dbz),  64'd0);
    chk("rst hi",   64'(bus.hi),   64'd0);
    chk("rst lo",   64'(bus.lo),   64'd0);
    rst = 1'b0;

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op("mult_neg4", OP_MULT,  32'hFFFF_FFFC, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b0);
    run_op("mult_7xm3", OP_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div_m7_2",  OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_7_m2",  OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_dbz",  OP_DIVU,  32'h0000_0004, 32'h0000_0000, 1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 1'b1);
    run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("div_dbz",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

    // MTHI and MTLO together, then MTLO alone
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h1234_5678;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("mt_both hi", 64'(bus.hi), 64'h1234_5678);
    chk("mt_both lo", 64'(bus.lo), 64'h1234_5678);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_ABCD;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("mtlo lo", 64'(bus.lo), 64'h0000_ABCD);
    chk("mtlo hi", 64'(bus.hi), 64'h1234_5678);

    // start with hi_we in the same cycle: write is dropped
    run_op("start_hiwe", OP_MULTU, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'h0000_0000, 32'h0000_000F, 1'b0);

    // reset in the middle of DIVU 100/7
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.x     = 32'd100;
    bus.y     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort hi",   64'(bus.hi),   64'd0);
    chk("abort lo",   64'(bus.lo),   64'd0);
    rst = 1'b0;
    saw_done = bus.done;
    repeat (30) begin
      @(negedge clk);
      saw_done = saw_done | bus.done;
    end
    chk("abort no_done", 64'(saw_done), 64'd0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the ALU. It takes the same x/y operand pair and produces the 64-bit products and quotient/remainder that the single-cycle ALU cannot produce in one cycle.
- The control unit issues MULT/MULTU/DIV/DIVU/MTHI/MTLO to it and stalls the pipeline on busy. MFHI/MFLO read hi/lo directly.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  issue operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- x  input  WIDTH  multiplicand / dividend (rs)
- y  input  WIDTH  multiplier / divisor (rt)
- hi_we  input  1  MTHI write strobe
- lo_we  input  1  MTLO write strobe
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  high from the cycle after start through the FIX cycle
- done  output  1  one-cycle pulse when hi/lo are updated
- dbz  output  1  divide-by-zero flag, valid with done, held until next start
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, dbz=0, hi=0, lo=0; counter=0.
- rst asserted mid-operation aborts on that edge: no done pulse, hi/lo=0.
- States:
  - IDLE: start=1 → latch op, |x|, |y| (signed ops only), result sign bits, counter=WIDTH → CALC.
  - CALC: one iteration per cycle; counter decrements; counter reaches 1 → FIX.
  - FIX: apply sign fix-up; write hi/lo; done=1 → IDLE.
- Latency: start sampled at edge N; busy high at N+1..N+WIDTH+1; done and new hi/lo visible after edge N+WIDTH+1, i.e. 33 cycles for WIDTH=32. Fixed latency for every op, including divide-by-zero.
- Multiply: shift-add over a 2*WIDTH accumulator.
  - MULTU: unsigned.
  - MULT: product negated if sign(x)^sign(y).
  - {hi,lo} = full 64-bit product.
- Divide: restoring, one quotient bit per cycle.
  - lo = quotient, hi = remainder.
  - DIV: quotient negated if sign(x)^sign(y); remainder takes the sign of x.
  - 0x80000000 / 0xFFFFFFFF (DIV) → lo=0x80000000, hi=0, no trap.
- Divide by zero (y==0): lo=0xFFFFFFFF, hi=x as issued, dbz=1.
- MTHI/MTLO: in IDLE with start=0, hi_we loads hi and lo_we loads lo at the edge. Both strobes may fire in the same cycle.
- Simultaneous events:
  - start with hi_we/lo_we in IDLE: start wins, writes dropped.
  - hi_we/lo_we while busy: ignored.
  - start while busy: ignored (control must hold stall).
- hi/lo hold the previous values during CALC; they change only at the FIX edge or on an MT write.
- x/y/op may change after the start cycle without effect.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU.
  - state encodings S_IDLE/S_CALC/S_FIX.
  - DBZ_LO constant 0xFFFFFFFF.
- One sub-module is natural: muldiv_core, holding the datapath (accumulator, shift/subtract step, sign fix-up) with step/load controls.
- The top-level muldiv_hilo holds the FSM, counter and HI/LO registers.

Test Plan:
- MULTU x=0xFFFFFFFF, y=0x00000002 → after 33 cycles done=1, hi=0x00000001, lo=0xFFFFFFFE; busy high exactly 33 cycles.
- MULT x=0xFFFFFFFC (-4), y=0x00000002 → hi=0xFFFFFFFF, lo=0xFFFFFFF8. DIV x=-7 (0xFFFFFFF9), y=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU x=4, y=0 → lo=0xFFFFFFFF, hi=0x00000004, dbz=1, latency 33 cycles.
- DIV x=0x80000000, y=0xFFFFFFFF → lo=0x80000000, hi=0x00000000, dbz=0.
- MTHI wdata=0x12345678 and MTLO in the same idle cycle → hi=lo=0x12345678 next cycle. hi_we during busy → hi unchanged. start+hi_we in IDLE → operation runs, write dropped.
- Issue DIVU 100/7, assert rst at cycle 10 → next cycle busy=0, hi=lo=0, no done pulse. A fresh DIVU 100/7 then gives lo=14, hi=2.
